clint_tmr_sched: RTL and testbench
==================================

CLINT_TMR_SCHED -- requirements
Module: clint_tmr_sched

Interface
REQ-001 SHALL have parameter NUM_TMR, default 4, number of virtual timer slots (2..16).
REQ-002 SHALL have parameter TIME_WIDTH, default 64, width of the mtime and deadline values.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port mtime_i, input, TIME_WIDTH, current timer value from the CLINT.
REQ-006 SHALL have port req_valid_i, input, 1, request strobe.
REQ-007 SHALL have port req_ready_o, output, 1, request accept.
REQ-008 SHALL have port req_op_i, input, 1: 0 = ARM, 1 = CANCEL.
REQ-009 SHALL have port req_id_i, input, clog2(NUM_TMR), slot index.
REQ-010 SHALL have port req_deadline_i, input, TIME_WIDTH, absolute deadline; used only by ARM.
REQ-011 SHALL have port mtimecmp_o, output, TIME_WIDTH, compare value for the CLINT.
REQ-012 SHALL have port mtimecmp_wr_o, output, 1, one-cycle pulse that loads mtimecmp_o into the CLINT.
REQ-013 SHALL have port expire_o, output, NUM_TMR, one-cycle pulse per expired slot.
REQ-014 SHALL have port armed_o, output, NUM_TMR, per-slot armed flags.
REQ-015 SHALL have port busy_o, output, 1, high whenever the FSM is not IDLE.

Function
REQ-016 SHALL use the FSM states IDLE, SCAN, PROG and FIRE.
REQ-017 SHALL accept a request when req_valid_i && req_ready_o; req_ready_o = (state==IDLE) && !due.
REQ-018 due SHALL equal win_vld && (mtime_i >= win_dl), as an unsigned TIME_WIDTH compare with no wrap handling.
REQ-019 On accepted ARM, SHALL set armed[id] and dl[id] = req_deadline_i; re-arming an armed slot overwrites it.
REQ-020 On accepted CANCEL, SHALL clear armed[id]; cancelling an unarmed slot is legal and only causes a rescan.
REQ-021 After an accept, SHALL go to SCAN on the next cycle.
REQ-022 In IDLE with due, SHALL go to FIRE; due has priority over a request in the same cycle.
REQ-023 SCAN SHALL visit slot 0..NUM_TMR-1, one slot per cycle, tracking the minimum deadline among armed slots.
REQ-024 In SCAN, ties SHALL go to the lowest index, and the scan SHALL restart from empty (no winner).
REQ-025 After the last slot, SHALL go to PROG.
REQ-026 PROG, lasting 1 cycle, SHALL latch win_vld, win_id and win_dl and pulse mtimecmp_wr_o.
REQ-027 In PROG, SHALL drive mtimecmp_o = win_dl, or all-ones if nothing is armed; then go to IDLE.
REQ-028 FIRE, lasting 1 cycle, SHALL pulse expire_o[win_id], clear armed[win_id] and win_vld, drive mtimecmp_o all-ones without a write pulse, then go to SCAN.
REQ-029 Request-accept to mtimecmp_wr_o latency SHALL be exactly NUM_TMR+1 cycles.
REQ-030 A deadline already in the past SHALL produce an expire pulse in the cycle after returning to IDLE.
REQ-031 Multiple slots due SHALL each fire in successive FIRE/SCAN/PROG rounds, in deadline then index order.
REQ-032 mtimecmp_o SHALL hold its value between updates; expire_o and mtimecmp_wr_o are never high together.

Reset
REQ-033 While rst_i is high, SHALL reset state to IDLE, and armed, expire_o, mtimecmp_wr_o, win_vld and busy_o to 0.
REQ-034 Under the same reset, SHALL clear dl[] to 0 and set mtimecmp_o to all-ones.
REQ-035 Reset asserted mid-SCAN or mid-FIRE SHALL abort immediately, with no expire or write pulse.
REQ-036 req_ready_o SHALL be 1 in the first cycle after reset release.

Structure
REQ-037 The FSM state enum, the op encodings (ARM/CANCEL) and default widths SHALL live in the shared package clint_sched_pkg.
REQ-038 The per-slot armed/deadline storage SHALL be one sub-module, clint_sched_slots, with a write port and an index read port.
REQ-039 Registers SHALL use the codebase's existing dffr-style register cells.

Verification (NUM_TMR=4)
REQ-040 ARM id2 dl=100 at mtime=10 -> after 5 cycles mtimecmp_wr_o pulses with mtimecmp_o=100; at mtime=100, expire_o=4'b0100 for 1 cycle; armed_o=0; next PROG writes all-ones.
REQ-041 ARM id0 dl=50, then id3 dl=30 -> second PROG writes 30; id3 fires at mtime=30, then PROG writes 50; id0 fires at 50.
REQ-042 ARM id1 dl=40, then CANCEL id1 before 40 -> PROG writes all-ones; no expire pulse ever.
REQ-043 ARM id1 and id2 both dl=20 while mtime=25 -> id1 fires, then id2 fires in the next round; req_ready_o is low during FIRE.
REQ-044 Request presented in the same IDLE cycle that due rises -> FIRE first with req_ready_o=0; the request is accepted in the next IDLE cycle.
REQ-045 rst_i pulsed mid-SCAN with 2 slots armed -> all outputs return to reset values, mtimecmp_o all-ones, no pulses.

Source files
------------

// File: rtl/clint_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clint_sched_pkg                                                  |
// | Shared types and constants for the CLINT virtual-timer scheduler |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package clint_sched_pkg;

  localparam int DEF_NUM_TMR    = 4;
  localparam int DEF_TIME_WIDTH = 64;

  // Request opcodes carried on req_op_i
  localparam logic OP_ARM    = 1'b0;
  localparam logic OP_CANCEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_PROG = 2'd2,
    ST_FIRE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/clint_tmr_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clint_tmr_sched_if                                               |
// | Request / CLINT-side signal bundle of the timer scheduler        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface clint_tmr_sched_if #(
  parameter int NUM_TMR    = clint_sched_pkg::DEF_NUM_TMR,
  parameter int TIME_WIDTH = clint_sched_pkg::DEF_TIME_WIDTH
);
  localparam int IDW = (NUM_TMR > 1) ? $clog2(NUM_TMR) : 1;

  logic [TIME_WIDTH-1:0] mtime_i;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_op_i;
  logic [IDW-1:0]        req_id_i;
  logic [TIME_WIDTH-1:0] req_deadline_i;
  logic [TIME_WIDTH-1:0] mtimecmp_o;
  logic                  mtimecmp_wr_o;
  logic [NUM_TMR-1:0]    expire_o;
  logic [NUM_TMR-1:0]    armed_o;
  logic                  busy_o;

  // The scheduler itself
  modport slave (
    input  mtime_i, req_valid_i, req_op_i, req_id_i, req_deadline_i,
    output req_ready_o, mtimecmp_o, mtimecmp_wr_o, expire_o, armed_o, busy_o
  );

  // Requester / CLINT side
  modport master (
    output mtime_i, req_valid_i, req_op_i, req_id_i, req_deadline_i,
    input  req_ready_o, mtimecmp_o, mtimecmp_wr_o, expire_o, armed_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/clint_sched_dffr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clint_sched_dffr                                                 |
// | Enabled register cell with asynchronous active-high reset        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module clint_sched_dffr #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  input  wire logic             i_en,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);
  // Load on enable, return to the reset value immediately on reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     o_q <= RST_VAL;
    else if (i_en) o_q <= i_d;
  end
endmodule
`default_nettype wire

// File: rtl/clint_sched_slots.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clint_sched_slots                                                |
// | Per-slot armed flag and deadline storage, one write port and     |
// | one indexed read port used by the scan                           |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module clint_sched_slots #(
  parameter int NUM_TMR    = 4,
  parameter int TIME_WIDTH = 64,
  parameter int IDW        = 2
) (
  input  wire logic                  i_clk,
  input  wire logic                  i_rst,
  input  wire logic                  i_we,
  input  wire logic                  i_arm,
  input  wire logic [IDW-1:0]        i_wr_id,
  input  wire logic [TIME_WIDTH-1:0] i_wr_dl,
  input  wire logic [IDW-1:0]        i_rd_id,
  output logic                       o_rd_armed,
  output logic [TIME_WIDTH-1:0]      o_rd_dl,
  output logic [NUM_TMR-1:0]         o_armed
);
  logic [TIME_WIDTH-1:0] r_dl [NUM_TMR];

  // A cancel only drops the armed flag; the stale deadline is never consulted
  generate
    for (genvar g = 0; g < NUM_TMR; g++) begin : g_slot
      logic w_hit;
      assign w_hit = i_we && (i_wr_id == IDW'(g));

      clint_sched_dffr #(.WIDTH(1)) u_armed (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_hit), .i_d(i_arm), .o_q(o_armed[g])
      );
      clint_sched_dffr #(.WIDTH(TIME_WIDTH)) u_dl (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_hit && i_arm), .i_d(i_wr_dl), .o_q(r_dl[g])
      );
    end
  endgenerate

  assign o_rd_armed = o_armed[i_rd_id];
  assign o_rd_dl    = r_dl[i_rd_id];
endmodule
`default_nettype wire

// File: rtl/clint_tmr_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clint_tmr_sched                                                  |
// | Multiplexes NUM_TMR virtual timers onto one CLINT mtimecmp by    |
// | scanning for the earliest armed deadline and firing due slots    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module clint_tmr_sched
  import clint_sched_pkg::*;
#(
  parameter int NUM_TMR    = DEF_NUM_TMR,
  parameter int TIME_WIDTH = DEF_TIME_WIDTH
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  clint_tmr_sched_if.slave bus
);
  localparam int                    IDW        = (NUM_TMR > 1) ? $clog2(NUM_TMR) : 1;
  localparam logic [TIME_WIDTH-1:0] c_ALL_ONES = '1;

  state_e                r_state, w_state_nxt;
  logic [IDW-1:0]        r_idx, w_idx_d;
  logic                  w_idx_en;
  logic                  r_acc_vld, w_acc_vld_d, w_acc_en;
  logic [IDW-1:0]        r_acc_id, w_acc_id_d;
  logic [TIME_WIDTH-1:0] r_acc_dl, w_acc_dl_d;
  logic                  r_win_vld;
  logic [IDW-1:0]        r_win_id;
  logic [TIME_WIDTH-1:0] r_win_dl;
  logic [TIME_WIDTH-1:0] r_cmp, w_cmp_d;
  logic                  w_cmp_en;
  logic                  w_we, w_arm;
  logic [IDW-1:0]        w_wr_id;
  logic                  w_rd_armed;
  logic [TIME_WIDTH-1:0] w_rd_dl;
  logic [NUM_TMR-1:0]    w_armed;
  logic                  w_due, w_ready, w_accept, w_take, w_last, w_is_prog;

  // Deadlines are plain unsigned compares; mtime wrap is not handled
  assign w_due     = r_win_vld && (bus.mtime_i >= r_win_dl);
  assign w_ready   = (r_state == ST_IDLE) && !w_due;
  assign w_accept  = bus.req_valid_i && w_ready;
  // Strict less-than keeps the lower index on equal deadlines
  assign w_take    = w_rd_armed && (!r_acc_vld || (w_rd_dl < r_acc_dl));
  assign w_last    = (r_idx == IDW'(NUM_TMR - 1));
  assign w_is_prog = (r_state == ST_PROG);

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, slot writes, scan accumulator and compare-value updates
  always_comb begin
    w_state_nxt = r_state;
    w_idx_en    = 1'b0;
    w_idx_d     = '0;
    w_acc_en    = 1'b0;
    w_acc_vld_d = 1'b0;
    w_acc_id_d  = r_acc_id;
    w_acc_dl_d  = r_acc_dl;
    w_cmp_en    = 1'b0;
    w_cmp_d     = c_ALL_ONES;
    w_we        = 1'b0;
    w_arm       = 1'b0;
    w_wr_id     = bus.req_id_i;
    unique case (r_state)
      ST_IDLE: begin
        if (w_due) begin
          w_state_nxt = ST_FIRE;
          w_cmp_en    = 1'b1;
        end else if (w_accept) begin
          w_we        = 1'b1;
          w_arm       = (bus.req_op_i == OP_ARM);
          w_state_nxt = ST_SCAN;
          w_idx_en    = 1'b1;
          w_acc_en    = 1'b1;
        end
      end
      ST_SCAN: begin
        w_acc_en    = 1'b1;
        w_idx_en    = 1'b1;
        w_idx_d     = w_last ? '0 : r_idx + IDW'(1);
        w_acc_vld_d = r_acc_vld;
        if (w_take) begin
          w_acc_vld_d = 1'b1;
          w_acc_id_d  = r_idx;
          w_acc_dl_d  = w_rd_dl;
        end
        // Stage the compare value so PROG presents it from a register
        if (w_last) begin
          w_state_nxt = ST_PROG;
          w_cmp_en    = 1'b1;
          w_cmp_d     = w_acc_vld_d ? w_acc_dl_d : c_ALL_ONES;
        end
      end
      ST_PROG: w_state_nxt = ST_IDLE;
      ST_FIRE: begin
        w_we        = 1'b1;
        w_wr_id     = r_win_id;
        w_state_nxt = ST_SCAN;
        w_idx_en    = 1'b1;
        w_acc_en    = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  clint_sched_dffr #(.WIDTH(IDW)) u_idx (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_idx_en), .i_d(w_idx_d), .o_q(r_idx));
  clint_sched_dffr #(.WIDTH(1)) u_acc_vld (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_acc_en), .i_d(w_acc_vld_d), .o_q(r_acc_vld));
  clint_sched_dffr #(.WIDTH(IDW)) u_acc_id (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_acc_en), .i_d(w_acc_id_d), .o_q(r_acc_id));
  clint_sched_dffr #(.WIDTH(TIME_WIDTH)) u_acc_dl (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_acc_en), .i_d(w_acc_dl_d), .o_q(r_acc_dl));

  // Winner is committed in PROG and retired in FIRE
  clint_sched_dffr #(.WIDTH(1)) u_win_vld (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_is_prog || (r_state == ST_FIRE)),
    .i_d(w_is_prog && r_acc_vld), .o_q(r_win_vld));
  clint_sched_dffr #(.WIDTH(IDW)) u_win_id (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_is_prog), .i_d(r_acc_id), .o_q(r_win_id));
  clint_sched_dffr #(.WIDTH(TIME_WIDTH)) u_win_dl (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_is_prog), .i_d(r_acc_dl), .o_q(r_win_dl));

  clint_sched_dffr #(.WIDTH(TIME_WIDTH), .RST_VAL(c_ALL_ONES)) u_cmp (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_cmp_en), .i_d(w_cmp_d), .o_q(r_cmp));

  clint_sched_slots #(.NUM_TMR(NUM_TMR), .TIME_WIDTH(TIME_WIDTH), .IDW(IDW)) u_slots (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_we      (w_we),
    .i_arm     (w_arm),
    .i_wr_id   (w_wr_id),
    .i_wr_dl   (bus.req_deadline_i),
    .i_rd_id   (r_idx),
    .o_rd_armed(w_rd_armed),
    .o_rd_dl   (w_rd_dl),
    .o_armed   (w_armed)
  );

  assign bus.req_ready_o   = w_ready;
  assign bus.mtimecmp_o    = r_cmp;
  assign bus.mtimecmp_wr_o = w_is_prog;
  assign bus.expire_o      = (r_state == ST_FIRE) ? (NUM_TMR'(1) << r_win_id) : '0;
  assign bus.armed_o       = w_armed;
  assign bus.busy_o        = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_clint_tmr_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_clint_tmr_sched                                               |
// | Self-checking bench: per-cycle reference model, vector table,    |
// | directed corner sequences and randomized traffic                 |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_clint_tmr_sched;
  localparam int          N      = 4;
  localparam int          TW     = 64;
  localparam logic [63:0] c_ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  clint_tmr_sched_if #(.NUM_TMR(N), .TIME_WIDTH(TW)) bus ();

  clint_tmr_sched #(.NUM_TMR(N), .TIME_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (observable behaviour) ----------------
  logic [N-1:0]  m_armed;
  logic [63:0]   m_dl [N];
  logic          m_win_vld, m_pend_vld, m_fire;
  logic [1:0]    m_win_id, m_pend_id;
  logic [63:0]   m_win_dl, m_pend_dl, m_cmp;
  int            m_cnt;          // busy cycles left: N scan cycles then one program cycle
  logic          e_busy, e_due;

  task automatic model_reset();
    m_armed = '0;
    for (int i = 0; i < N; i++) m_dl[i] = '0;
    m_win_vld = 0; m_win_id = 0; m_win_dl = 0;
    m_pend_vld = 0; m_pend_id = 0; m_pend_dl = 0;
    m_cmp = c_ONES; m_cnt = 0; m_fire = 0;
  endtask

  // Earliest deadline among armed slots, lowest index on ties
  task automatic model_pick();
    logic [63:0] best;
    int          who;
    best = c_ONES; who = -1;
    for (int i = 0; i < N; i++)
      if (m_armed[i] && (who < 0 || m_dl[i] < best)) begin best = m_dl[i]; who = i; end
    m_pend_vld = (who >= 0);
    m_pend_id  = (who >= 0) ? 2'(who) : 2'd0;
    m_pend_dl  = best;
    m_cnt      = N + 1;
  endtask

  task automatic model_step(input logic due);
    if (m_fire) begin
      m_armed[m_win_id] = 1'b0;
      m_win_vld = 0; m_fire = 0;
      model_pick();
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 1) m_cmp = m_pend_vld ? m_pend_dl : c_ONES;
      if (m_cnt == 0) begin m_win_vld = m_pend_vld; m_win_id = m_pend_id; m_win_dl = m_pend_dl; end
    end else if (due) begin
      m_fire = 1; m_cmp = c_ONES;
    end else if (bus.req_valid_i) begin
      if (bus.req_op_i == 1'b0) begin
        m_armed[bus.req_id_i] = 1'b1;
        m_dl[bus.req_id_i]    = bus.req_deadline_i;
      end else begin
        m_armed[bus.req_id_i] = 1'b0;
      end
      model_pick();
    end
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    e_busy = m_fire || (m_cnt != 0);
    e_due  = m_win_vld && (bus.mtime_i >= m_win_dl);
    check("ready",  bus.req_ready_o,   !e_busy && !e_due);
    check("wr",     bus.mtimecmp_wr_o, !m_fire && (m_cnt == 1));
    check("cmp",    bus.mtimecmp_o,    m_cmp);
    check("expire", bus.expire_o,      m_fire ? (4'b0001 << m_win_id) : 4'b0000);
    check("armed",  bus.armed_o,       m_armed);
    check("busy",   bus.busy_o,        e_busy);
    if (!rst) model_step(e_due);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_mtime(input logic [63:0] v);
    @(posedge clk); #1 bus.mtime_i = v;
  endtask

  task automatic wait_wr(output logic [63:0] cmpv);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.mtimecmp_wr_o && k < 60) begin @(negedge clk); k++; end
    check("wr_timeout", (k < 60), 1);
    cmpv = bus.mtimecmp_o;
  endtask

  task automatic do_req(input logic op, input logic [1:0] id, input logic [63:0] dl,
                        input bit wait_for_wr, output int lat, output logic [63:0] cmpv);
    int k;
    k = 0;
    @(posedge clk); #1;
    bus.req_valid_i = 1; bus.req_op_i = op; bus.req_id_i = id; bus.req_deadline_i = dl;
    @(negedge clk);
    while (!bus.req_ready_o && k < 60) begin @(negedge clk); k++; end
    check("accept_timeout", (k < 60), 1);
    @(posedge clk); #1 bus.req_valid_i = 0;
    lat = 0; cmpv = 0;
    if (wait_for_wr) begin
      lat = 1;
      @(negedge clk);
      while (!bus.mtimecmp_wr_o && lat < 60) begin @(negedge clk); lat++; end
      cmpv = bus.mtimecmp_o;
    end
  endtask

  typedef struct {
    logic        op;
    logic [1:0]  id;
    logic [63:0] dl;
    logic [63:0] exp_cmp;
    logic [3:0]  exp_armed;
  } vec_t;
  vec_t tbl [10];

  int          lat, cnt;
  logic [63:0] cmpv;

  initial begin
    bus.mtime_i = 0; bus.req_valid_i = 0; bus.req_op_i = 0;
    bus.req_id_i = 0; bus.req_deadline_i = 0;

    tbl[0] = '{1'b0, 2'd2, 64'd100, 64'd100, 4'b0100};
    tbl[1] = '{1'b0, 2'd0, 64'd50,  64'd50,  4'b0101};
    tbl[2] = '{1'b0, 2'd3, 64'd30,  64'd30,  4'b1101};
    tbl[3] = '{1'b0, 2'd1, 64'd30,  64'd30,  4'b1111};
    tbl[4] = '{1'b1, 2'd1, 64'd0,   64'd30,  4'b1101};
    tbl[5] = '{1'b1, 2'd3, 64'd0,   64'd50,  4'b0101};
    tbl[6] = '{1'b1, 2'd3, 64'd0,   64'd50,  4'b0101};
    tbl[7] = '{1'b0, 2'd0, 64'd200, 64'd100, 4'b0101};
    tbl[8] = '{1'b1, 2'd2, 64'd0,   64'd200, 4'b0001};
    tbl[9] = '{1'b1, 2'd0, 64'd0,   c_ONES,  4'b0000};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmp", bus.mtimecmp_o, c_ONES);
    check("rst_armed", bus.armed_o, 0);
    check("rst_busy", bus.busy_o, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("ready_after_rst", bus.req_ready_o, 1);

    // Vector table at mtime=0: nothing can fire
    for (int v = 0; v < 10; v++) begin
      do_req(tbl[v].op, tbl[v].id, tbl[v].dl, 1, lat, cmpv);
      check("tbl_latency", lat, N + 1);
      check("tbl_cmp", cmpv, tbl[v].exp_cmp);
      check("tbl_armed", bus.armed_o, tbl[v].exp_armed);
    end

    // Single timer armed then fired
    set_mtime(10);
    do_req(1'b0, 2'd2, 64'd100, 1, lat, cmpv);
    check("s1_latency", lat, N + 1);
    check("s1_cmp", cmpv, 64'd100);
    set_mtime(100);
    @(negedge clk); check("s1_ready_due", bus.req_ready_o, 0);
    @(negedge clk); check("s1_expire", bus.expire_o, 4'b0100);
    check("s1_no_wr_in_fire", bus.mtimecmp_wr_o, 0);
    @(negedge clk); check("s1_expire_clr", bus.expire_o, 0);
    check("s1_armed", bus.armed_o, 0);
    wait_wr(cmpv); check("s1_cmp_ones", cmpv, c_ONES);

    // Two timers, earlier one armed second
    set_mtime(0);
    do_req(1'b0, 2'd0, 64'd50, 1, lat, cmpv); check("s2_cmp_a", cmpv, 64'd50);
    do_req(1'b0, 2'd3, 64'd30, 1, lat, cmpv); check("s2_cmp_b", cmpv, 64'd30);
    set_mtime(30);
    @(negedge clk);
    @(negedge clk); check("s2_fire3", bus.expire_o, 4'b1000);
    wait_wr(cmpv); check("s2_cmp_next", cmpv, 64'd50);
    set_mtime(50);
    @(negedge clk);
    @(negedge clk); check("s2_fire0", bus.expire_o, 4'b0001);
    wait_wr(cmpv); check("s2_cmp_ones", cmpv, c_ONES);

    // Due rises in the same IDLE cycle a request is presented
    do_req(1'b0, 2'd1, 64'd70, 1, lat, cmpv); check("s3_cmp", cmpv, 64'd70);
    @(posedge clk); #1;
    bus.mtime_i = 70;
    bus.req_valid_i = 1; bus.req_op_i = 0; bus.req_id_i = 2; bus.req_deadline_i = 500;
    @(negedge clk); check("s3_ready_due", bus.req_ready_o, 0);
    @(negedge clk); check("s3_fire1", bus.expire_o, 4'b0010);
    check("s3_ready_fire", bus.req_ready_o, 0);
    cnt = 0;
    while (!bus.req_ready_o && cnt < 60) begin @(negedge clk); cnt++; end
    check("s3_accept_timeout", (cnt < 60), 1);
    @(posedge clk); #1 bus.req_valid_i = 0;
    wait_wr(cmpv); check("s3_cmp_after", cmpv, 64'd500);
    check("s3_armed", bus.armed_o, 4'b0100);

    // Equal past deadlines fire in successive rounds
    set_mtime(25);
    do_req(1'b0, 2'd1, 64'd20, 1, lat, cmpv); check("s4_cmp_a", cmpv, 64'd20);
    @(negedge clk); check("s4_ready_due", bus.req_ready_o, 0);
    @(negedge clk); check("s4_fire1", bus.expire_o, 4'b0010);
    check("s4_ready_fire", bus.req_ready_o, 0);
    do_req(1'b0, 2'd2, 64'd20, 1, lat, cmpv); check("s4_cmp_b", cmpv, 64'd20);
    @(negedge clk);
    @(negedge clk); check("s4_fire2", bus.expire_o, 4'b0100);
    wait_wr(cmpv); check("s4_cmp_ones", cmpv, c_ONES);

    // Cancel before the deadline: never fires
    set_mtime(0);
    do_req(1'b0, 2'd1, 64'd40, 1, lat, cmpv); check("s5_cmp_a", cmpv, 64'd40);
    do_req(1'b1, 2'd1, 64'd0, 1, lat, cmpv); check("s5_cmp_ones", cmpv, c_ONES);
    set_mtime(100);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (bus.expire_o != 0) cnt++; end
    check("s5_no_expire", cnt, 0);

    // Reset asserted mid-scan
    do_req(1'b0, 2'd0, 64'd1000, 1, lat, cmpv);
    do_req(1'b0, 2'd3, 64'd2000, 1, lat, cmpv);
    do_req(1'b0, 2'd1, 64'd3000, 0, lat, cmpv);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("s6_cmp", bus.mtimecmp_o, c_ONES);
    check("s6_armed", bus.armed_o, 0);
    check("s6_busy", bus.busy_o, 0);
    check("s6_wr", bus.mtimecmp_wr_o, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk); check("s6_ready", bus.req_ready_o, 1);
    cnt = 0;
    repeat (8) begin @(negedge clk); if (bus.mtimecmp_wr_o || bus.expire_o != 0) cnt++; end
    check("s6_no_pulse", cnt, 0);

    // Randomized traffic against the model
    set_mtime(200);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst                = ($urandom_range(0, 399) == 0);
      bus.mtime_i        = bus.mtime_i + 64'($urandom_range(0, 2));
      bus.req_valid_i    = ($urandom_range(0, 3) == 0);
      bus.req_op_i       = ($urandom_range(0, 3) == 0);
      bus.req_id_i       = 2'($urandom_range(0, 3));
      bus.req_deadline_i = bus.mtime_i + 64'($urandom_range(0, 80)) - 64'd10;
    end
    @(posedge clk); #1 rst = 0; bus.req_valid_i = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
